dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `data_memory` between the `mips` core and a DMA/loader requester. It grants one transaction per cycle using round-robin on contention, drives the memory strobes from the winning port, and returns registered read data to the winner one cycle later. It also snoops writes to the result address `8'hFF`, latching the value and raising a sticky `done` flag for the program-completion check.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Port identities double as the bit index of each port inside req/gnt vectors.
package dmem_arb_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 16;

    localparam logic [7:0] DONE_ADDR_DEFAULT = 8'hFF;

    localparam int GNT_CPU = 0;
    localparam int GNT_DMA = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the last-winner pointer only moves on
// contention, so a lone requester never disturbs the tie-break order.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_e last_q;
    port_e last_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PORT_DMA;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (req == 2'b11) begin
            last_d = gnt[GNT_DMA] ? PORT_DMA : PORT_CPU;
        end
    end

    // On a tie the port that did not win the previous tie is served.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == PORT_DMA) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU and a DMA/loader port,
// returns registered read data to the winner and snoops the completion address.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int            AW        = AW_DEFAULT,
    parameter int            DW        = DW_DEFAULT,
    parameter logic [AW-1:0] DONE_ADDR = AW'(DONE_ADDR_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,

    output logic [AW-1:0] d_addr,
    output logic [DW-1:0] w_data,
    output logic          d_wr,
    output logic          d_rd,
    input  logic [DW-1:0] r_data,

    output logic          done,
    output logic [DW-1:0] result
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       sel_we;

    assign req = {dma_req, cpu_req};

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign cpu_gnt = gnt[GNT_CPU];
    assign dma_gnt = gnt[GNT_DMA];
    assign any_gnt = |gnt;

    // With no grant the bus idles on the CPU port's address and data.
    always_comb begin
        d_addr = cpu_addr;
        w_data = cpu_wdata;
        sel_we = cpu_we;
        if (gnt[GNT_DMA]) begin
            d_addr = dma_addr;
            w_data = dma_wdata;
            sel_we = dma_we;
        end
    end

    assign d_wr = any_gnt &  sel_we;
    assign d_rd = any_gnt & ~sel_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= r_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) begin
                dma_rdata <= r_data;
            end
        end
    end

    // The completion write still reaches memory; this only observes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done   <= 1'b0;
            result <= '0;
        end else if (d_wr && (d_addr == DONE_ADDR)) begin
            done   <= 1'b1;
            result <= w_data;
        end
    end

    strobe_exclusive: assert property (@(posedge clk) disable iff (!rst) !(d_wr && d_rd));
    grant_onehot:     assert property (@(posedge clk) disable iff (!rst) !(cpu_gnt && dma_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory on the bus, a reference model
// with per-port read scoreboards, a vector table and a few hand sequences.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, d_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, w_data, r_data;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] cpu_rdata, dma_rdata, result;
    logic          d_wr, d_rd, done;

    dmem_arbiter #(.AW(AW), .DW(DW), .DONE_ADDR(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .d_addr     (d_addr),
        .w_data     (w_data),
        .d_wr       (d_wr),
        .d_rd       (d_rd),
        .r_data     (r_data),
        .done       (done),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        logic [7:0] a;
        a = i[7:0];
        case (a)
            8'h10:   return 16'h1234;
            8'h01:   return 16'hA001;
            8'h02:   return 16'hB002;
            default: return {a ^ 8'hA5, a};
        endcase
    endfunction

    // Memory seen by the DUT; it reloads while reset is held.
    logic [15:0] mem [256];
    assign r_data = mem[d_addr];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (d_wr) begin
            mem[d_addr] <= w_data;
        end
    end

    typedef struct {
        logic        cr, cw;
        logic [7:0]  ca;
        logic [15:0] cd;
        logic        dr, dw;
        logic [7:0]  da;
        logic [15:0] dd;
        logic [1:0]  eg;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ref_mem [256];
    logic        m_last;
    logic        m_cpu_rv, m_dma_rv, m_done;
    logic [15:0] m_cpu_rdata, m_dma_rdata, m_result;
    logic [15:0] cpu_q[$];
    logic [15:0] dma_q[$];

    function automatic vec_t mk(input logic cr, input logic cw, input logic [7:0] ca,
                                input logic [15:0] cd, input logic dr, input logic dw,
                                input logic [7:0] da, input logic [15:0] dd,
                                input logic [1:0] eg);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.eg = eg;
        return v;
    endfunction

    function automatic logic [1:0] model_gnt(input logic cr, input logic dr);
        if (cr && dr) return m_last ? 2'b01 : 2'b10;
        return {dr, cr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m_last      = 1'b1;
        m_cpu_rv    = 1'b0;
        m_dma_rv    = 1'b0;
        m_done      = 1'b0;
        m_cpu_rdata = '0;
        m_dma_rdata = '0;
        m_result    = '0;
        cpu_q.delete();
        dma_q.delete();
    endtask

    task automatic model_step(input vec_t v);
        logic [1:0] g;
        g = model_gnt(v.cr, v.dr);
        m_cpu_rv = g[0] & ~v.cw;
        m_dma_rv = g[1] & ~v.dw;
        if (m_cpu_rv) cpu_q.push_back(ref_mem[v.ca]);
        if (m_dma_rv) dma_q.push_back(ref_mem[v.da]);
        if (g[0] && v.cw) begin
            ref_mem[v.ca] = v.cd;
            if (v.ca == 8'hFF) begin m_done = 1'b1; m_result = v.cd; end
        end
        if (g[1] && v.dw) begin
            ref_mem[v.da] = v.dd;
            if (v.da == 8'hFF) begin m_done = 1'b1; m_result = v.dd; end
        end
        if (v.cr && v.dr) m_last = g[1];
    endtask

    task automatic check_output(input vec_t v);
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_wd;
        exp_we   = v.eg[1] ? v.dw : v.cw;
        exp_addr = v.eg[1] ? v.da : v.ca;
        exp_wd   = v.eg[1] ? v.dd : v.cd;
        check("gnt",      {30'd0, dma_gnt, cpu_gnt}, {30'd0, v.eg});
        check("d_wr",     {31'd0, d_wr}, {31'd0, (|v.eg) & exp_we});
        check("d_rd",     {31'd0, d_rd}, {31'd0, (|v.eg) & ~exp_we});
        check("d_addr",   {24'd0, d_addr}, {24'd0, exp_addr});
        check("w_data",   {16'd0, w_data}, {16'd0, exp_wd});
        check("strobe_excl", {31'd0, d_wr & d_rd}, 32'd0);
        if (m_cpu_rv) begin
            if (cpu_q.size() == 0) check("cpu_sb_empty", 32'd0, 32'd1);
            else m_cpu_rdata = cpu_q.pop_front();
        end
        if (m_dma_rv) begin
            if (dma_q.size() == 0) check("dma_sb_empty", 32'd0, 32'd1);
            else m_dma_rdata = dma_q.pop_front();
        end
        check("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, m_cpu_rv});
        check("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, m_dma_rv});
        check("cpu_rdata",  {16'd0, cpu_rdata},  {16'd0, m_cpu_rdata});
        check("dma_rdata",  {16'd0, dma_rdata},  {16'd0, m_dma_rdata});
        check("done",       {31'd0, done},       {31'd0, m_done});
        check("result",     {16'd0, result},     {16'd0, m_result});
    endtask

    // Inputs change just after a rising edge, outputs are checked on the falling edge.
    task automatic apply_stimulus(input vec_t v);
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
        @(negedge clk);
        check_output(v);
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
        check({tag, "_dma_rvalid"}, {31'd0, dma_rvalid}, 32'd0);
        check({tag, "_cpu_rdata"},  {16'd0, cpu_rdata},  32'd0);
        check({tag, "_dma_rdata"},  {16'd0, dma_rdata},  32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_result"},     {16'd0, result},     32'd0);
    endtask

    vec_t vecs[14];
    vec_t idle;

    initial begin
        vec_t v;
        int   miss_run;

        idle = mk(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 2'b00);
        vecs[0]  = mk(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000, 2'b01);
        vecs[1]  = idle;
        vecs[2]  = mk(1, 0, 8'h01, 16'h0000, 1, 0, 8'h02, 16'h0000, 2'b01);
        vecs[3]  = mk(1, 0, 8'h01, 16'h0000, 1, 0, 8'h02, 16'h0000, 2'b10);
        vecs[4]  = mk(1, 0, 8'h01, 16'h0000, 1, 0, 8'h02, 16'h0000, 2'b01);
        vecs[5]  = mk(1, 0, 8'h01, 16'h0000, 1, 0, 8'h02, 16'h0000, 2'b10);
        vecs[6]  = mk(0, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'hBEEF, 2'b10);
        vecs[7]  = mk(1, 0, 8'h20, 16'h0000, 0, 0, 8'h00, 16'h0000, 2'b01);
        vecs[8]  = mk(1, 1, 8'hFF, 16'h000D, 0, 0, 8'h00, 16'h0000, 2'b01);
        vecs[9]  = mk(0, 0, 8'h00, 16'h0000, 1, 1, 8'hFF, 16'h0001, 2'b10);
        vecs[10] = mk(1, 1, 8'h30, 16'h1111, 1, 1, 8'h31, 16'h2222, 2'b01);
        vecs[11] = mk(1, 0, 8'h30, 16'h0000, 1, 1, 8'h31, 16'h2222, 2'b10);
        vecs[12] = mk(1, 0, 8'h30, 16'h0000, 0, 0, 8'h00, 16'h0000, 2'b01);
        vecs[13] = idle;

        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        rst = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 14; i++) apply_stimulus(vecs[i]);

        $display("[TB] reset during read return");
        apply_stimulus(mk(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0, 2'b01));
        cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(idle);
        apply_stimulus(mk(1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0, 2'b01));
        apply_stimulus(idle);

        $display("[TB] continuous contention");
        miss_run = 0;
        for (int i = 0; i < 8; i++) begin
            v = mk(1, 0, 8'(8'h41 + i), 16'h0, 1, 0, 8'h40, 16'h0, 2'b00);
            v.eg = model_gnt(v.cr, v.dr);
            apply_stimulus(v);
            miss_run = v.eg[1] ? 0 : miss_run + 1;
            check("dma_starve", {31'd0, miss_run > 1}, 32'd0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            v.cr = 1'($urandom_range(0, 1));
            v.cw = 1'($urandom_range(0, 1));
            v.ca = 8'hF8 | 8'($urandom_range(0, 7));
            v.cd = 16'($urandom);
            v.dr = 1'($urandom_range(0, 1));
            v.dw = 1'($urandom_range(0, 1));
            v.da = 8'hF8 | 8'($urandom_range(0, 7));
            v.dd = 16'($urandom);
            v.eg = model_gnt(v.cr, v.dr);
            apply_stimulus(v);
        end
        apply_stimulus(idle);
        apply_stimulus(idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
